// File: rtl/hack_boot_loader_if.sv
// Byte-stream receive side and instruction-memory write side of the Hack boot loader.
interface hack_boot_loader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [7:0]        i_RX_DATA;
  logic              i_RX_VALID;
  logic              i_BOOT_REQ;
  logic              o_ROM_WE;
  logic [ADDR_W-1:0] o_ROM_ADDR;
  logic [15:0]       o_ROM_DATA;
  logic              o_CPU_RESET_n;
  logic              o_BUSY;
  logic              o_ERROR;

  modport master (
    output i_RX_DATA, i_RX_VALID, i_BOOT_REQ,
    input  o_ROM_WE, o_ROM_ADDR, o_ROM_DATA, o_CPU_RESET_n, o_BUSY, o_ERROR
  );

  modport slave (
    input  i_RX_DATA, i_RX_VALID, i_BOOT_REQ,
    output o_ROM_WE, o_ROM_ADDR, o_ROM_DATA, o_CPU_RESET_n, o_BUSY, o_ERROR
  );
endinterface

// File: rtl/hack_boot_loader.sv
// Boot sequencer: loads a length-prefixed 16-bit program image from a byte stream
// into instruction memory while holding the CPU in reset, then releases it.
module hack_boot_loader #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input logic               i_CLK,
  input logic               i_RESET_n,
  hack_boot_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    WORD_HI,
    WORD_LO,
    RUN,
    ERR
  } state_t;

  state_t            state, next_state;
  logic [7:0]        hi_byte;
  logic [15:0]       len;
  logic [CNT_W-1:0]  idx;
  logic [TMR_W-1:0]  timer;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              cpu_reset_n;

  logic [15:0] len_word;
  logic        too_long;
  logic        last_word;
  logic        waiting;
  logic        timeout;

  assign len_word  = {hi_byte, bus.i_RX_DATA};
  assign too_long  = 32'(len_word) > (32'd1 << ADDR_W);
  assign last_word = (32'(idx) + 32'd1) == 32'(len);
  assign waiting   = (state == LEN_LO) || (state == WORD_HI) || (state == WORD_LO);
  // ERR is entered on the same edge at which the idle timer reaches TIMEOUT_CYC.
  assign timeout   = waiting && !bus.i_RX_VALID && (timer == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) state <= LEN_HI;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.i_BOOT_REQ) begin
      next_state = LEN_HI;
    end else begin
      case (state)
        LEN_HI:  if (bus.i_RX_VALID) next_state = LEN_LO;
        LEN_LO: begin
          if (bus.i_RX_VALID) begin
            if (len_word == '0)  next_state = RUN;
            else if (too_long)   next_state = ERR;
            else                 next_state = WORD_HI;
          end else if (timeout) begin
            next_state = ERR;
          end
        end
        WORD_HI: begin
          if (bus.i_RX_VALID)  next_state = WORD_LO;
          else if (timeout)    next_state = ERR;
        end
        WORD_LO: begin
          if (bus.i_RX_VALID)  next_state = last_word ? RUN : WORD_HI;
          else if (timeout)    next_state = ERR;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      hi_byte     <= '0;
      len         <= '0;
      idx         <= '0;
      timer       <= '0;
      rom_we      <= 1'b0;
      rom_addr    <= '0;
      rom_data    <= '0;
      cpu_reset_n <= 1'b0;
    end else begin
      rom_we      <= 1'b0;
      cpu_reset_n <= (next_state == RUN);

      if (bus.i_BOOT_REQ || bus.i_RX_VALID || !waiting) timer <= '0;
      else                                              timer <= timer + 1'b1;

      // A write launched by the previous WORD_LO byte is already on the bus,
      // so a boot request only has to rewind the loader.
      if (bus.i_BOOT_REQ) begin
        idx <= '0;
      end else if (bus.i_RX_VALID) begin
        case (state)
          LEN_HI:  hi_byte <= bus.i_RX_DATA;
          LEN_LO: begin
            len <= len_word;
            idx <= '0;
          end
          WORD_HI: hi_byte <= bus.i_RX_DATA;
          WORD_LO: begin
            rom_we   <= 1'b1;
            rom_data <= len_word;
            rom_addr <= idx[ADDR_W-1:0];
            idx      <= idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.o_ROM_WE      = rom_we;
    bus.o_ROM_ADDR    = rom_addr;
    bus.o_ROM_DATA    = rom_data;
    bus.o_CPU_RESET_n = cpu_reset_n;
    bus.o_BUSY        = waiting || (state == LEN_HI);
    bus.o_ERROR       = (state == ERR);
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: per-cycle vector table plus hand sequences.
module tb_hack_boot_loader;

  logic r_CLK;
  logic r_RESET_n;
  int   checks;
  int   passes;

  hack_boot_loader_if #(.ADDR_W(4)) bus ();

  hack_boot_loader #(.ADDR_W(4), .TIMEOUT_CYC(100)) dut (
    .i_CLK     (r_CLK),
    .i_RESET_n (r_RESET_n),
    .bus       (bus.slave)
  );

  initial r_CLK = 1'b0;
  always #5 r_CLK = ~r_CLK;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        cpu;
    logic        busy;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic req,
                     input logic we, input logic [3:0] addr, input logic [15:0] data,
                     input logic cpu, input logic busy, input logic err, input string name);
    vec_t t;
    t.v = v; t.d = d; t.req = req; t.we = we; t.addr = addr; t.data = data;
    t.cpu = cpu; t.busy = busy; t.err = err; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge sample them, return 1 ns after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic req);
    bus.i_RX_VALID = v;
    bus.i_RX_DATA  = d;
    bus.i_BOOT_REQ = req;
    @(posedge r_CLK);
    #1;
    bus.i_RX_VALID = 1'b0;
    bus.i_RX_DATA  = 8'h00;
    bus.i_BOOT_REQ = 1'b0;
  endtask

  task automatic chk_status(input string name, input logic cpu, input logic busy, input logic err);
    chk({name, " cpu"},  32'(bus.o_CPU_RESET_n), 32'(cpu));
    chk({name, " busy"}, 32'(bus.o_BUSY), 32'(busy));
    chk({name, " err"},  32'(bus.o_ERROR), 32'(err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt;
    int k;
    logic [15:0] w;
    checks = 0;
    passes = 0;
    bus.i_RX_VALID = 1'b0;
    bus.i_RX_DATA  = 8'h00;
    bus.i_BOOT_REQ = 1'b0;
    r_RESET_n = 1'b0;

    // Image 00 02 | EC 10 | E3 08
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "t1 len_hi");
    add(1, 8'h02, 0, 0, 0, 16'h0000, 0, 1, 0, "t1 len_lo");
    add(1, 8'hEC, 0, 0, 0, 16'h0000, 0, 1, 0, "t1 w0 hi");
    add(1, 8'h10, 0, 1, 0, 16'hEC10, 0, 1, 0, "t1 w0 lo");
    add(1, 8'hE3, 0, 0, 0, 16'h0000, 0, 1, 0, "t1 w1 hi");
    add(1, 8'h08, 0, 1, 1, 16'hE308, 1, 0, 0, "t1 w1 lo");
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, "t1 run");
    add(1, 8'h55, 0, 0, 0, 16'h0000, 1, 0, 0, "t1 rx ignored");
    // Reload from RUN: 00 01 | 00 07
    add(0, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0, "t5 req");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "t5 len_hi");
    add(1, 8'h01, 0, 0, 0, 16'h0000, 0, 1, 0, "t5 len_lo");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "t5 w0 hi");
    add(1, 8'h07, 0, 1, 0, 16'h0007, 1, 0, 0, "t5 w0 lo");
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, "t5 run");
    // Empty image
    add(0, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0, "t2 req");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "t2 len_hi");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, "t2 len_lo");
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, "t2 run");
    // Boot request collides with second length byte
    add(0, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0, "t6 req");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "t6 len_hi");
    add(1, 8'h01, 1, 0, 0, 16'h0000, 0, 1, 0, "t6 req wins");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "t6 len_hi2");
    add(1, 8'h01, 0, 0, 0, 16'h0000, 0, 1, 0, "t6 len_lo2");
    add(1, 8'h12, 0, 0, 0, 16'h0000, 0, 1, 0, "t6 w0 hi");
    add(1, 8'h34, 0, 1, 0, 16'h1234, 1, 0, 0, "t6 w0 lo");
    // Boot request right after a WORD_LO byte: that write still completes
    add(0, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0, "pw req");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "pw len_hi");
    add(1, 8'h02, 0, 0, 0, 16'h0000, 0, 1, 0, "pw len_lo");
    add(1, 8'hAB, 0, 0, 0, 16'h0000, 0, 1, 0, "pw w0 hi");
    add(1, 8'hCD, 0, 1, 0, 16'hABCD, 0, 1, 0, "pw w0 lo");
    add(0, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0, "pw req2");
    add(1, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 0, "pw len_hi2");
    add(1, 8'h01, 0, 0, 0, 16'h0000, 0, 1, 0, "pw len_lo2");
    add(1, 8'h56, 0, 0, 0, 16'h0000, 0, 1, 0, "pw w0 hi2");
    add(1, 8'h78, 0, 1, 0, 16'h5678, 1, 0, 0, "pw w0 lo2");

    // Reset state
    #3;
    chk("rst we",   32'(bus.o_ROM_WE), 32'd0);
    chk("rst addr", 32'(bus.o_ROM_ADDR), 32'd0);
    chk("rst data", 32'(bus.o_ROM_DATA), 32'd0);
    chk_status("rst", 0, 1, 0);
    @(negedge r_CLK);
    r_RESET_n = 1'b1;
    @(negedge r_CLK);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].req);
      chk({vecs[i].name, " we"}, 32'(bus.o_ROM_WE), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk({vecs[i].name, " addr"}, 32'(bus.o_ROM_ADDR), 32'(vecs[i].addr));
        chk({vecs[i].name, " data"}, 32'(bus.o_ROM_DATA), 32'(vecs[i].data));
      end
      chk_status(vecs[i].name, vecs[i].cpu, vecs[i].busy, vecs[i].err);
    end

    // Largest image that fits (N = 16), bytes back to back
    step(0, 8'h00, 1);
    step(1, 8'h00, 0);
    step(1, 8'h10, 0);
    chk_status("n16 len", 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      w = 16'hA000 + 16'(i * 17);
      step(1, w[15:8], 0);
      chk("n16 hi we", 32'(bus.o_ROM_WE), 32'd0);
      step(1, w[7:0], 0);
      chk("n16 lo we",   32'(bus.o_ROM_WE), 32'd1);
      chk("n16 lo addr", 32'(bus.o_ROM_ADDR), 32'(i));
      chk("n16 lo data", 32'(bus.o_ROM_DATA), 32'(w));
      chk("n16 cpu", 32'(bus.o_CPU_RESET_n), (i == 15) ? 32'd1 : 32'd0);
    end
    chk_status("n16 run", 1, 0, 0);

    // Oversized image (N = 17) is rejected; only a boot request recovers
    step(0, 8'h00, 1);
    step(1, 8'h00, 0);
    step(1, 8'h11, 0);
    chk_status("n17 err", 0, 0, 1);
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    chk("n17 rx ignored we", 32'(bus.o_ROM_WE), 32'd0);
    chk_status("n17 stay err", 0, 0, 1);
    step(0, 8'h00, 1);
    chk_status("n17 req", 0, 1, 0);

    // No timeout while waiting for the first length byte
    for (int i = 0; i < 150; i++) step(0, 8'h00, 0);
    chk_status("len_hi no timeout", 0, 1, 0);

    // Idle timeout mid-image: 00 03 AA then silence
    step(1, 8'h00, 0);
    step(1, 8'h03, 0);
    step(1, 8'hAA, 0);
    we_cnt = 0;
    for (int i = 0; i < 98; i++) begin
      step(0, 8'h00, 0);
      if (bus.o_ROM_WE) we_cnt++;
    end
    chk_status("timeout early", 0, 1, 0);
    k = 98;
    while (!bus.o_ERROR && k < 110) begin
      step(0, 8'h00, 0);
      if (bus.o_ROM_WE) we_cnt++;
      k++;
    end
    chk("timeout idle cycles in range", 32'(k >= 99 && k <= 101), 32'd1);
    chk("timeout no we", 32'(we_cnt), 32'd0);
    chk_status("timeout err", 0, 0, 1);
    step(1, 8'h77, 0);
    chk_status("timeout stay err", 0, 0, 1);

    // Asynchronous reset while in WORD_LO
    step(0, 8'h00, 1);
    step(1, 8'h00, 0);
    step(1, 8'h02, 0);
    step(1, 8'h12, 0);
    step(1, 8'h34, 0);
    chk("ar first write", 32'(bus.o_ROM_DATA), 32'h1234);
    step(1, 8'h56, 0);
    r_RESET_n = 1'b0;
    #1;
    chk("ar we",   32'(bus.o_ROM_WE), 32'd0);
    chk("ar addr", 32'(bus.o_ROM_ADDR), 32'd0);
    chk("ar data", 32'(bus.o_ROM_DATA), 32'd0);
    chk_status("ar", 0, 1, 0);
    @(negedge r_CLK);
    r_RESET_n = 1'b1;
    @(negedge r_CLK);
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    step(1, 8'hBE, 0);
    step(1, 8'hEF, 0);
    chk("ar reload we",   32'(bus.o_ROM_WE), 32'd1);
    chk("ar reload addr", 32'(bus.o_ROM_ADDR), 32'd0);
    chk("ar reload data", 32'(bus.o_ROM_DATA), 32'hBEEF);
    chk_status("ar reload", 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
